// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRIAL  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Width of the trial counter: it must hold the value WIDTH itself.
  function automatic int iter_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// MSB-first successive-approximation controller driving a magnitude comparator's B operand.
// Optional flag sanity check enabled by defining SAR_FLAG_CHECK_EN.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = iter_w(WIDTH),
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_equal,
  input  logic             cmp_greater,
  input  logic             cmp_small,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    iter_cnt,
  output logic             flag_err
);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] trial_r, trial_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic [WIDTH-1:0] mask_s, decided_s;
  logic [BW-1:0]    bit_idx_r, bit_idx_nxt_s;
  logic [CW-1:0]    iter_r, iter_nxt_s;
  logic             found_r, found_nxt_s;
  logic             flag_err_r, flag_err_nxt_s;
  logic             busy_r, done_r;
  logic             flag_bad_s, last_s, finish_s;

`ifdef SAR_FLAG_CHECK_EN
  assign flag_bad_s = ~onehot3({cmp_equal, cmp_greater, cmp_small});
`else
  // Greater is implied whenever neither Equal nor Small is set.
  logic unused_greater_s;
  assign unused_greater_s = cmp_greater;
  assign flag_bad_s       = 1'b0;
`endif

  // Bit decision for the current trial
  always_comb begin
    mask_s    = WIDTH'(1) << bit_idx_r;
    decided_s = cmp_small ? (trial_r & ~mask_s) : trial_r;
    last_s    = (bit_idx_r == BW'(0));
    finish_s  = flag_bad_s | cmp_equal | last_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = TRIAL;
        else       state_nxt_s = IDLE;
      end
      TRIAL: begin
        if (finish_s) state_nxt_s = FINISH;
        else          state_nxt_s = TRIAL;
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the datapath and held results
  always_comb begin
    trial_nxt_s    = {WIDTH{1'b0}};
    bit_idx_nxt_s  = bit_idx_r;
    result_nxt_s   = result_r;
    found_nxt_s    = found_r;
    iter_nxt_s     = iter_r;
    flag_err_nxt_s = flag_err_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          trial_nxt_s    = WIDTH'(1) << (WIDTH - 1);
          bit_idx_nxt_s  = BW'(WIDTH - 1);
          iter_nxt_s     = CW'(0);
          found_nxt_s    = 1'b0;
          flag_err_nxt_s = 1'b0;
        end else begin
          trial_nxt_s    = {WIDTH{1'b0}};
        end
      end
      TRIAL: begin
        iter_nxt_s = iter_r + CW'(1);
        if (flag_bad_s) begin
          result_nxt_s   = {WIDTH{1'b0}};
          found_nxt_s    = 1'b0;
          flag_err_nxt_s = 1'b1;
        end else if (cmp_equal) begin
          result_nxt_s = trial_r;
          found_nxt_s  = 1'b1;
        end else if (last_s) begin
          result_nxt_s = decided_s;
          found_nxt_s  = 1'b0;
        end else begin
          trial_nxt_s   = decided_s | (mask_s >> 1);
          bit_idx_nxt_s = bit_idx_r - BW'(1);
        end
      end
      FINISH:  trial_nxt_s = {WIDTH{1'b0}};
      default: trial_nxt_s = {WIDTH{1'b0}};
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      trial_r    <= {WIDTH{1'b0}};
      bit_idx_r  <= {BW{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      found_r    <= 1'b0;
      iter_r     <= {CW{1'b0}};
      flag_err_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      trial_r    <= trial_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      result_r   <= result_nxt_s;
      found_r    <= found_nxt_s;
      iter_r     <= iter_nxt_s;
      flag_err_r <= flag_err_nxt_s;
      busy_r     <= (state_nxt_s == TRIAL);
      done_r     <= (state_nxt_s == FINISH);
    end
  end

  assign guess    = trial_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign found    = found_r;
  assign result   = result_r;
  assign iter_cnt = iter_r;
  assign flag_err = flag_err_r;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl: a comparator model closes the loop on a target value,
// expected outcomes come from an arithmetic binary-search reference model.
module tb_sar_search_ctrl;

  typedef struct packed {
    logic [15:0] gseq;
    logic [2:0]  nguess;
    logic [3:0]  result;
    logic        found;
    logic [2:0]  iter;
    logic        ferr;
    logic [31:0] done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       bad_req = 1'b0;
  logic [3:0] target = 4'd0;
  logic       cmp_equal, cmp_greater, cmp_small, bad_now;
  logic [3:0] guess, result;
  logic [2:0] iter_cnt;
  logic       busy, done, found, flag_err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] obs_seq;
  int   obs_n;

  sar_search_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_equal(cmp_equal), .cmp_greater(cmp_greater), .cmp_small(cmp_small),
    .guess(guess), .busy(busy), .done(done), .found(found),
    .result(result), .iter_cnt(iter_cnt), .flag_err(flag_err)
  );

  // Comparator with A=target, B=guess; bad_now corrupts the flags on the first trial.
  assign bad_now     = bad_req & busy & (iter_cnt == 3'd0);
  assign cmp_equal   = (target == guess);
  assign cmp_greater = bad_now | (target > guess);
  assign cmp_small   = bad_now | (target < guess);

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain binary search over [0,15] counting the probes it makes.
  function automatic exp_t model(input logic [3:0] tgt, input bit bad, input int sc);
    exp_t e;
    int   value, g, n;
    bit   stop, err;
    e = '0; value = 0; n = 0; stop = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!stop) begin
        g = value + (1 << i);
        e.gseq[n*4 +: 4] = 4'(g);
        n++;
        err = 1'b0;
`ifdef SAR_FLAG_CHECK_EN
        err = bad && (i == 3);
`endif
        if (err) begin
          e.ferr = 1'b1; value = 0; stop = 1'b1;
        end else if (int'(tgt) == g) begin
          e.found = 1'b1; value = g; stop = 1'b1;
        end else if (!(bad && i == 3) && int'(tgt) > g) begin
          value = g;
        end
      end
    end
    e.result   = 4'(value);
    e.nguess   = 3'(n);
    e.iter     = 3'(n);
    e.done_cyc = 32'(sc + n + 1);
    return e;
  endfunction

  // Monitor: collect guesses while busy, pop and compare on every done pulse.
  initial begin
    obs_seq = 16'd0;
    obs_n   = 0;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (obs_n < 4) obs_seq[obs_n*4 +: 4] = guess;
        obs_n++;
      end else if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("result",   int'(result),   int'(mon_e.result));
          chk("found",    int'(found),    int'(mon_e.found));
          chk("iter_cnt", int'(iter_cnt), int'(mon_e.iter));
          chk("flag_err", int'(flag_err), int'(mon_e.ferr));
          chk("done_cycle", cyc, int'(mon_e.done_cyc));
          chk("n_guesses", obs_n, int'(mon_e.nguess));
          chk("guess_seq", int'(obs_seq), int'(mon_e.gseq));
        end
        obs_seq = 16'd0;
        obs_n   = 0;
      end else begin
        obs_seq = 16'd0;
        obs_n   = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run_search(input logic [3:0] tgt, input bit bad);
    wait_idle();
    target  = tgt;
    bad_req = bad;
    start   = 1'b1;
    sb.push_back(model(tgt, bad, cyc));
    @(negedge clk);
    start = 1'b0;
    wait_done();
    bad_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_guess"},    int'(guess),    0);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_done"},     int'(done),     0);
    chk({tag, "_found"},    int'(found),    0);
    chk({tag, "_result"},   int'(result),   0);
    chk({tag, "_iter_cnt"}, int'(iter_cnt), 0);
    chk({tag, "_flag_err"}, int'(flag_err), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_search(4'd6, 1'b0);
    run_search(4'd15, 1'b0);
    run_search(4'd8, 1'b0);

    // target 0, with start pulses while busy and in the done cycle
    wait_idle();
    target = 4'd0;
    start  = 1'b1;
    sb.push_back(model(4'd0, 1'b0, cyc));
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);

    // start held high: second search begins in the IDLE cycle after FINISH
    begin
      int c0;
      wait_idle();
      target = 4'd3;
      start  = 1'b1;
      c0 = cyc;
      sb.push_back(model(4'd3, 1'b0, c0));
      sb.push_back(model(4'd3, 1'b0, c0 + 6));
      repeat (7) @(negedge clk);
      start = 1'b0;
      wait_done();
    end

    // reset during the second trial aborts silently
    wait_idle();
    target = 4'd5;
    start  = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_search(4'd5, 1'b0);

    // corrupted flags on the first trial, then a clean search
    run_search(4'd5, 1'b1);
    repeat (2) @(negedge clk);
`ifdef SAR_FLAG_CHECK_EN
    chk("flag_err_sticky", int'(flag_err), 1);
`else
    chk("flag_err_tied", int'(flag_err), 0);
`endif
    run_search(4'd9, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [3:0] t;
      bit b;
      t = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_search(t, b);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
